// File: rtl/mips_muldiv.sv
`default_nettype none
// ============================================================================
// mips_muldiv : iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers
// Revision    : 1.0
// ============================================================================
module mips_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic               r_op_div;
    logic               r_neg_a;
    logic               r_neg_b;
    logic [WIDTH-1:0]   r_opb;
    logic [WIDTH-1:0]   r_rs_raw;
    logic [2*WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_div_zero;

    logic               w_signed;
    logic [WIDTH-1:0]   w_abs_rs;
    logic [WIDTH-1:0]   w_abs_rt;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH:0]     w_diff;
    logic               w_qbit;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    // Operands are reduced to magnitudes; signs are reapplied at FINISH.
    assign w_signed = ~op[0];
    assign w_abs_rs = (w_signed && rs_data[WIDTH-1]) ? -rs_data : rs_data;
    assign w_abs_rt = (w_signed && rt_data[WIDTH-1]) ? -rt_data : rt_data;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend/quotient bits}, shifted left.
    assign w_trial    = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_diff     = w_trial - {1'b0, r_opb};
    assign w_qbit     = ~w_diff[WIDTH];
    assign w_div_next = {(w_qbit ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0]),
                         r_acc[WIDTH-2:0], w_qbit};

    always_comb begin
        w_prod   = (r_neg_a ^ r_neg_b) ? -r_acc : r_acc;
        w_quo    = (r_neg_a ^ r_neg_b) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_rem    = r_neg_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
        w_res_hi = w_prod[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod[WIDTH-1:0];
        if (r_op_div) begin
            if (r_div_zero) begin
                w_res_hi = r_rs_raw;
                w_res_lo = '1;
            end else begin
                w_res_hi = w_rem;
                w_res_lo = w_quo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_CALC;
            S_CALC:   if (r_count == C_LAST) w_next = S_FINISH;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_div   <= 1'b0;
            r_neg_a    <= 1'b0;
            r_neg_b    <= 1'b0;
            r_opb      <= '0;
            r_rs_raw   <= '0;
            r_acc      <= '0;
            r_count    <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done <= (r_state == S_FINISH);
            case (r_state)
                S_IDLE: begin
                    if (hi_we) r_hi <= wr_data;
                    if (lo_we) r_lo <= wr_data;
                    if (start) begin
                        r_op_div   <= op[1];
                        r_neg_a    <= w_signed & rs_data[WIDTH-1];
                        r_neg_b    <= w_signed & rt_data[WIDTH-1];
                        r_rs_raw   <= rs_data;
                        r_count    <= '0;
                        r_div_zero <= op[1] && (rt_data == '0);
                        r_acc      <= {{WIDTH{1'b0}}, (op[1] ? w_abs_rs : w_abs_rt)};
                        r_opb      <= op[1] ? w_abs_rt : w_abs_rs;
                    end
                end
                S_CALC: begin
                    r_acc   <= r_op_div ? w_div_next : w_mul_next;
                    r_count <= r_count + 1'b1;
                end
                S_FINISH: begin
                    r_hi <= w_res_hi;
                    r_lo <= w_res_lo;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mips_muldiv.sv
`default_nettype none
// ============================================================================
// tb_mips_muldiv : directed self-checking bench for mips_muldiv
// Revision       : 1.0
// ============================================================================
module tb_mips_muldiv;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    int lat, busy_cnt, done_cnt, hold_ok, dz_at1;

    mips_muldiv #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Launches one operation and observes 40 negedges; poke_at>0 fires a
    // start plus MTHI/MTLO and garbage operands in the middle of the run.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int poke_at);
        logic [31:0] h0, l0;
        h0 = hi;
        l0 = lo;
        op = o; rs_data = a; rt_data = b; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        rs_data = $urandom;
        rt_data = $urandom;
        lat = 0; busy_cnt = 0; done_cnt = 0; hold_ok = 1; dz_at1 = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i == 1) dz_at1 = int'(div_zero);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (lat == 0) lat = i;
            end
            if (i <= 33 && (hi !== h0 || lo !== l0)) hold_ok = 0;
            start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            if (i == poke_at) begin
                start = 1'b1; hi_we = 1'b1; lo_we = 1'b1;
                wr_data = 32'hDEADBEEF;
                op = ~o;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
        hi_we = 1'b0; lo_we = 1'b0; wr_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_dz", {31'd0, div_zero}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        check("multu_hi", hi, 32'hFFFFFFFE);
        check("multu_lo", lo, 32'h00000001);
        check("multu_latency", lat, 32'd34);
        check("multu_busy_cycles", busy_cnt, 32'd33);
        check("multu_done_pulses", done_cnt, 32'd1);
        check("multu_hold", hold_ok, 32'd1);

        do_op(2'b00, 32'hFFFFFFFD, 32'd7, 10);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFEB);
        check("mult_done_pulses", done_cnt, 32'd1);
        check("mult_hold_mt_ignored", hold_ok, 32'd1);

        do_op(2'b10, 32'hFFFFFFF9, 32'd2, 0);
        check("div_lo", lo, 32'hFFFFFFFD);
        check("div_hi", hi, 32'hFFFFFFFF);

        do_op(2'b11, 32'hFFFFFFF9, 32'd2, 0);
        check("divu_lo", lo, 32'h7FFFFFFC);
        check("divu_hi", hi, 32'h00000001);

        do_op(2'b10, 32'd7, 32'hFFFFFFFE, 0);
        check("div_pos_neg_lo", lo, 32'hFFFFFFFD);
        check("div_pos_neg_hi", hi, 32'h00000001);

        do_op(2'b11, 32'h00001234, 32'd0, 0);
        check("divu0_lo", lo, 32'hFFFFFFFF);
        check("divu0_hi", hi, 32'h00001234);
        check("divu0_dz", {31'd0, div_zero}, 32'd1);

        do_op(2'b01, 32'h00010000, 32'h00010000, 0);
        check("dz_cleared_on_start", dz_at1, 32'd0);
        check("multu2_hi", hi, 32'h00000001);
        check("multu2_lo", lo, 32'h00000000);

        do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 0);
        check("div_ovf_lo", lo, 32'h80000000);
        check("div_ovf_hi", hi, 32'h00000000);
        check("div_ovf_dz", {31'd0, div_zero}, 32'd0);

        do_op(2'b10, 32'hFFFFFFF9, 32'd0, 0);
        check("div0_neg_lo", lo, 32'hFFFFFFFF);
        check("div0_neg_hi", hi, 32'hFFFFFFF9);
        check("div0_neg_dz", {31'd0, div_zero}, 32'd1);

        do_op(2'b00, 32'h80000000, 32'h80000000, 0);
        check("mult_min_hi", hi, 32'h40000000);
        check("mult_min_lo", lo, 32'h00000000);

        hi_we = 1'b1; wr_data = 32'hA5A5A5A5;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi_idle", hi, 32'hA5A5A5A5);
        lo_we = 1'b1; wr_data = 32'h5A5A5A5A;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo_idle", lo, 32'h5A5A5A5A);

        op = 2'b01; rs_data = 32'h12345678; rt_data = 32'h9ABCDEF0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("busy_before_rst", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_hi", hi, 32'd0);
        check("rst_mid_lo", lo, 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        check("rst_mid_no_done", done_cnt, 32'd0);
        check("rst_mid_lo_after", lo, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_muldiv.md
Name: mips_muldiv

Overview:
- Iterative multiply/divide unit for the execute stage of the MIPS core. Sits beside the ALU.
- Consumes rs_data/rt_data from the register file under decoder control and owns the architectural HI/LO registers.
- Implements MULT, MULTU, DIV and DIVU as a multi-cycle operation, plus the MTHI/MTLO writes.
- The core stalls on busy before issuing MFHI/MFLO or another mult/div.

Parameters:
- width, 32, operand width; HI and LO are each width bits; iteration count equals width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset.
- start  input  1  launch an operation; sampled only when busy=0.
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs_data  input  width  multiplicand or dividend.
- rt_data  input  width  multiplier or divisor.
- hi_we  input  1  MTHI: write wr_data into HI.
- lo_we  input  1  MTLO: write wr_data into LO.
- wr_data  input  width  data for MTHI/MTLO.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; HI/LO hold the new result.
- div_zero  output  1  last completed divide had rt_data==0; sticky until the next start.
- hi  output  width  HI register.
- lo  output  width  LO register.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0. Reset mid-operation aborts the operation; no partial result is written.
- FSM states: IDLE, CALC, FINISH.
  - IDLE, start=1 → CALC. Latch op, |rs|, |rt|, both sign bits, count=0 and div_zero=(op[1] && rt_data==0). Clear div_zero otherwise.
  - CALC: one iteration per cycle, count increments. At count==width-1 → FINISH.
  - FINISH: apply sign fix, write HI/LO, pulse done → IDLE.
- Latency: start sampled at edge E0.
  - Iterations occur on E1..E32; result is written at E33.
  - busy=1 from after E0 until after E33 (33 cycles).
  - done=1 for exactly the cycle following E33. busy=(state!=IDLE).
- Multiply: radix-2 shift-add on magnitudes into a 2*width accumulator.
  - Signed (MULT): negate the 64-bit product if the sign bits differ.
  - HI=product[63:32], LO=product[31:0].
- Divide: restoring, one quotient bit per cycle, on magnitudes.
  - Signed (DIV): quotient is negated if the sign bits differ; remainder takes the sign of the dividend.
  - LO=quotient, HI=remainder.
- Divide by zero: no sign fix. LO=32'hFFFFFFFF, HI=rs_data as latched. div_zero=1.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (two's-complement wrap, no trap).
- Unsigned ops treat operands as unsigned; no sign handling at all.
- start while busy=1: ignored; latched operands and op are unaffected.
- hi_we/lo_we:
  - Take effect at the next edge only when busy=0.
  - Ignored while busy=1.
  - Same cycle as an accepted start: the MT write happens at E0 and is overwritten by the result at E33.
- hi/lo change only at an MT write, at FINISH, or at reset. They hold their previous values throughout CALC.
- Operands are latched at start; changes to rs_data/rt_data during CALC have no effect.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. done high exactly 34 cycles after the start cycle; busy high 33 cycles.
- MULT rs=0xFFFFFFFD (-3), rt=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. Second start pulsed mid-operation is ignored (single done pulse, same result).
- DIV rs=0xFFFFFFF9 (-7), rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU same operands → lo=0x7FFFFFFC, hi=0x00000001.
- DIVU rs=0x1234, rt=0 → lo=0xFFFFFFFF, hi=0x00001234, div_zero=1. Next MULTU start clears div_zero.
- DIV rs=0x80000000, rt=0xFFFFFFFF → lo=0x80000000, hi=0x00000000, div_zero=0.
- hi_we with wr_data=0xA5A5A5A5 while idle → hi=0xA5A5A5A5 next cycle. lo_we during busy → lo unchanged. rst asserted at iteration 10 → busy=0, hi=lo=0 next cycle, no done pulse.
